// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Define DCACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = DATA_WIDTH - IDX_W - 2;
  localparam int BE_LANES = (DATA_WIDTH / 8 < 4) ? DATA_WIDTH / 8 : 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [SETS-1:0]       valid_q;
  logic [SETS-1:0]       dirty_q;

  logic [IDX_W-1:0]      index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic [TAG_W-1:0]      line_tag;
  logic                  line_valid;
  logic                  line_dirty;
  logic                  access;
  logic                  hit;
  logic [DATA_WIDTH-1:0] merged;
  logic                  store_we;
  logic                  refill_we;
  logic                  unused_offset;

  assign index         = cpu_addr[IDX_W+1:2];
  assign cpu_tag       = cpu_addr[DATA_WIDTH-1:IDX_W+2];
  assign unused_offset = ^cpu_addr[1:0];

  assign line_data  = data_q[index];
  assign line_tag   = tag_q[index];
  assign line_valid = valid_q[index];
  assign line_dirty = dirty_q[index];

  assign access = cpu_re | cpu_we;
  assign hit    = access & line_valid & (line_tag == cpu_tag);

  always_comb begin
    merged = line_data;
    for (int i = 0; i < BE_LANES; i++) begin
      if (cpu_be[i]) merged[8*i +: 8] = cpu_wdata[8*i +: 8];
    end
  end

  // Outputs are forced to their idle values while rst is high so an
  // abandoned transfer never leaks onto the memory bus.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    cpu_rdata = '0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    store_we  = 1'b0;
    refill_we = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            cpu_rdata = line_data;
            store_we  = cpu_we;
          end else if (access) begin
            stall   = 1'b1;
            state_d = (line_valid && line_dirty) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {line_tag, index, 2'b00};
          mem_wdata = line_data;
          if (mem_ready) state_d = REFILL;
        end
        REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {cpu_tag, index, 2'b00};
          if (mem_ready) begin
            refill_we = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: data and tag arrays carry no reset; valid_q qualifies every use of them.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_q[index] <= mem_rdata;
      tag_q[index]  <= cpu_tag;
    end else if (store_we) begin
      data_q[index] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill_we) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (store_we) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // The access replayed right after a refill hits, but it was already
  // counted as a miss, so replay_q keeps it out of hit_count.
  logic replay_q;
  logic count_hit;
  logic count_miss;

  assign count_hit  = !rst && (state_q == IDLE) && hit && !replay_q;
  assign count_miss = !rst && (state_q == IDLE) && access && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      replay_q <= refill_we;
      if (count_hit)  hit_count  <= hit_count + 32'd1;
      if (count_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of CPU and memory data.
REQ-002 Parameter SETS, default 256, number of one-word lines, power of two >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_re  input  1  memory-stage load request.
REQ-006 cpu_we  input  1  memory-stage store request; wins if cpu_re also high.
REQ-007 cpu_addr  input  DATA_WIDTH  byte address; bits [1:0] ignored for line selection.
REQ-008 cpu_wdata  input  DATA_WIDTH  store data, byte lanes aligned to address.
REQ-009 cpu_be  input  4  store byte enables.
REQ-010 cpu_rdata  output  DATA_WIDTH  load data, the full word of the hit line.
REQ-011 stall  output  1  freezes the pipeline while high.
REQ-012 mem_req  output  1  main-memory request valid.
REQ-013 mem_we  output  1  high for writeback, low for refill.
REQ-014 mem_addr  output  DATA_WIDTH  word-aligned memory address.
REQ-015 mem_wdata  output  DATA_WIDTH  victim data during writeback.
REQ-016 mem_rdata  input  DATA_WIDTH  refill data, valid when mem_ready is high.
REQ-017 mem_ready  input  1  one-cycle completion strobe for the current mem_req.

Function
REQ-018 Direct-mapped, write-back, write-allocate; per line: valid, dirty, tag, data.
REQ-019 index = cpu_addr[log2(SETS)+1:2]; tag = remaining upper bits.
REQ-020 hit = access (re|we) & valid[index] & tag match; combinational in the same cycle.
REQ-021 FSM states IDLE, WRITEBACK, REFILL; reset state IDLE.
REQ-022 IDLE, load hit: cpu_rdata = line data, stall=0, zero latency.
REQ-023 IDLE, store hit: enabled bytes merged into the line at the clock edge, dirty set, stall=0.
REQ-024 IDLE, miss: stall=1 in the same cycle; next state WRITEBACK if victim valid & dirty, else REFILL.
REQ-025 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index,2'b00}, mem_wdata=victim data; on mem_ready go to REFILL.
REQ-026 REFILL: mem_req=1, mem_we=0, mem_addr={cpu tag,index,2'b00}; on mem_ready write mem_rdata, set tag and valid, clear dirty, go to IDLE.
REQ-027 stall=1 in WRITEBACK and REFILL regardless of mem_ready; in IDLE the replayed access hits and completes per REQ-022/023.
REQ-028 mem_req, mem_we, mem_addr and mem_wdata hold stable until mem_ready; mem_ready while mem_req=0 is ignored.
REQ-029 No access (re=we=0): stall=0, no state change; cpu_rdata is don't-care.
REQ-030 CPU inputs are held stable by the pipeline while stall=1; the cache does not latch them.

Reset
REQ-031 rst clears all valid and dirty bits and forces IDLE, including mid-WRITEBACK or mid-REFILL (the pending transfer is abandoned).
REQ-032 During and after reset: stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0 until the first hit.

Configuration
REQ-033 Macro DCACHE_STATS_EN defined: 32-bit outputs hit_count and miss_count are added, both reset to 0, and wrap modulo 2^32.
REQ-034 hit_count increments on a first-cycle IDLE hit only; a replay after refill does not count. miss_count increments once per IDLE miss.
REQ-035 Macro undefined: neither the ports nor the counters exist; all other behaviour is identical.

Verification
REQ-036 After reset, load 0x100 with mem_rdata=0xDEADBEEF: stall=1 then REFILL at mem_addr 0x100; next IDLE cycle gives cpu_rdata=0xDEADBEEF, stall=0.
REQ-037 Store 0x100 with be=4'b0011, wdata=0x0000CAFE after REQ-036: no stall; a following load returns 0xDEADCAFE.
REQ-038 Then load 0x500 (SETS=256, same index): WRITEBACK with mem_addr 0x100, mem_wdata 0xDEADCAFE, then REFILL at 0x500.
REQ-039 Assert rst during REFILL with mem_ready held low: next cycle mem_req=0, stall=0; a load of 0x100 misses.
REQ-040 Assert cpu_re and cpu_we together on a hit: the store takes effect and dirty is set.
REQ-041 With DCACHE_STATS_EN, run the sequence in REQ-036 to REQ-038: hit_count=2, miss_count=2.
